// File: rtl/tcb_sub_mem.sv
// -----------------------------------------------------------------------------
// tcb_sub_mem
//   TCB subordinate memory. Word-organised RAM that answers TCB manager
//   requests. A transfer happens when vld_i & rdy_o. Writes are byte-enabled.
//   The read data / error response appears DLY clock periods after the
//   transfer, which must match the DLY of the attached tcb_if.
//
// Parameters
//   AW    address width
//   DW    data width (8/16/32/64)
//   BW    byte enable width (DW/8)
//   DLY   response delay 0..4 (0 = combinational read in the transfer cycle)
//   SIZE  memory size in bytes, power of two, multiple of BW
//   WAIT  wait states per transfer 0..15 (only with TCB_SUB_MEM_WAIT_EN)
//
// Ports
//   clk_i   clock
//   rst_i   synchronous active-high reset (memory contents are kept)
//   vld_i   request valid
//   wen_i   write enable (1 = write, 0 = read)
//   adr_i   byte address
//   ben_i   byte enables
//   wdt_i   write data
//   rdt_o   read data, holds its value outside read/error responses
//   err_o   error response (address out of range), high only in response cycles
//   rdy_o   ready
//
// Build option
//   TCB_SUB_MEM_WAIT_EN  when defined, rdy_o comes from an IDLE->WAIT->RDY
//                        FSM inserting WAIT wait states; otherwise rdy_o = 1.
// -----------------------------------------------------------------------------
module tcb_sub_mem #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned BW   = DW/8,
  parameter int unsigned DLY  = 1,
  parameter int unsigned SIZE = 4096,
  parameter int unsigned WAIT = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vld_i,
  input  logic          wen_i,
  input  logic [AW-1:0] adr_i,
  input  logic [BW-1:0] ben_i,
  input  logic [DW-1:0] wdt_i,
  output logic [DW-1:0] rdt_o,
  output logic          err_o,
  output logic          rdy_o
);

  localparam int unsigned ABW   = $clog2(SIZE);
  localparam int unsigned OBW   = $clog2(BW);
  localparam int unsigned IW    = ABW - OBW;
  localparam int unsigned WORDS = SIZE / BW;
  localparam int unsigned PD    = (DLY > 1) ? DLY - 1 : 1;

  // Out-of-range parameters elaborate this marker block so they are visible
  // in the hierarchy of a misconfigured instance.
  if (DLY > 4 || WAIT > 15) begin : g_param_out_of_range
  end

  logic [DW-1:0] mem_q [WORDS];
  logic          trn_s;
  logic          rng_s;
  logic [IW-1:0] idx_s;
  logic [DW-1:0] rd_dat_s;
  logic          err0_s;
  logic          upd0_s;

  assign trn_s    = vld_i & rdy_o;
  assign rng_s    = ((adr_i >> ABW) == '0);
  assign idx_s    = adr_i[ABW-1:OBW];
  assign rd_dat_s = rng_s ? mem_q[idx_s] : '0;
  assign err0_s   = trn_s & ~rng_s;
  // rdt changes for reads and for error transfers (forced to 0); a good write
  // only returns err=0 and leaves rdt alone.
  assign upd0_s   = trn_s & (~wen_i | ~rng_s);

  // Byte-enabled write; no reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (trn_s && wen_i && rng_s) begin
      for (int i = 0; i < int'(BW); i++) begin
        if (ben_i[i]) mem_q[idx_s][8*i +: 8] <= wdt_i[8*i +: 8];
      end
    end
  end

  if (DLY == 0) begin : g_async
    logic [DW-1:0] rdt_hold_q;

    // Remember the last returned read data so rdt_o holds between responses.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdt_hold_q <= '0;
      end else if (upd0_s) begin
        rdt_hold_q <= rd_dat_s;
      end
    end

    // Combinational response in the transfer cycle.
    always_comb begin
      if (upd0_s && !rst_i) begin
        rdt_o = rd_dat_s;
      end else begin
        rdt_o = rdt_hold_q;
      end
      err_o = err0_s & ~rst_i;
    end
  end else begin : g_sync
    logic          last_upd_s;
    logic          last_err_s;
    logic [DW-1:0] last_dat_s;
    logic [DW-1:0] rdt_q;
    logic          err_q;

    if (DLY == 1) begin : g_direct
      assign last_upd_s = upd0_s;
      assign last_err_s = err0_s;
      assign last_dat_s = rd_dat_s;
    end else begin : g_pipe
      logic          p_upd_q [PD];
      logic          p_err_q [PD];
      logic [DW-1:0] p_dat_q [PD];

      // Delay line for responses still in flight; reset drops them all.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < int'(PD); i++) begin
            p_upd_q[i] <= 1'b0;
            p_err_q[i] <= 1'b0;
            p_dat_q[i] <= '0;
          end
        end else begin
          p_upd_q[0] <= upd0_s;
          p_err_q[0] <= err0_s;
          p_dat_q[0] <= rd_dat_s;
          for (int i = 1; i < int'(PD); i++) begin
            p_upd_q[i] <= p_upd_q[i-1];
            p_err_q[i] <= p_err_q[i-1];
            p_dat_q[i] <= p_dat_q[i-1];
          end
        end
      end

      assign last_upd_s = p_upd_q[PD-1];
      assign last_err_s = p_err_q[PD-1];
      assign last_dat_s = p_dat_q[PD-1];
    end

    // Output register: err pulses for one cycle, rdt holds until next read/error.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdt_q <= '0;
        err_q <= 1'b0;
      end else begin
        err_q <= last_err_s;
        if (last_upd_s) rdt_q <= last_dat_s;
      end
    end

    assign rdt_o = rdt_q;
    assign err_o = err_q;
  end

`ifdef TCB_SUB_MEM_WAIT_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RDY  = 2'd2;

  logic [1:0] st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rdy_q;

  // Wait-state sequencing; dropping vld while waiting abandons the request.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_IDLE: begin
        if (!vld_i) begin
          st_d = ST_IDLE;
        end else if (WAIT == 32'd0) begin
          st_d = ST_RDY;
        end else begin
          st_d  = ST_WAIT;
          cnt_d = 4'(WAIT) - 4'd1;
        end
      end
      ST_WAIT: begin
        if (!vld_i) begin
          st_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          st_d = ST_RDY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RDY: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and registered ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= ST_IDLE;
      cnt_q <= 4'd0;
      rdy_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      rdy_q <= (st_d == ST_RDY);
    end
  end

  assign rdy_o = rdy_q;
`else
  assign rdy_o = 1'b1;
`endif

endmodule

// File: tb/tb_tcb_sub_mem.sv
module tb_tcb_sub_mem;

  localparam int unsigned SIZE = 4096;
  localparam int ND = 4;   // instances with DLY = 0..3

`ifdef TCB_SUB_MEM_WAIT_EN
  localparam logic RDY_IDLE = 1'b0;
`else
  localparam logic RDY_IDLE = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst, vld, wen;
  logic [31:0] adr, wdt;
  logic [3:0]  ben;
  logic [31:0] rdt_s [ND];
  logic        err_s [ND];
  logic        rdy_s [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    tcb_sub_mem #(.AW(32), .DW(32), .DLY(g), .SIZE(SIZE), .WAIT(2)) u_dut (
      .clk_i (clk), .rst_i (rst), .vld_i (vld), .wen_i (wen),
      .adr_i (adr), .ben_i (ben), .wdt_i (wdt),
      .rdt_o (rdt_s[g]), .err_o (err_s[g]), .rdy_o (rdy_s[g])
    );
  end

  // ---------------- reference model ----------------
  logic [7:0]  mbyte [SIZE];
  int          cyc, last_rst;
  bit          rst_prev, last_trn;
  bit          h_vld [16], h_err [16], h_upd [16];
  logic [31:0] h_dat [16];
  int          h_cyc [16];
  logic [31:0] exp_rdt [ND];
  logic        exp_err [ND];
  int          passed, total;

  function automatic logic [31:0] mword(input logic [31:0] a);
    int b;
    b = int'({a[11:2], 2'b00});
    return {mbyte[b+3], mbyte[b+2], mbyte[b+1], mbyte[b]};
  endfunction

  // One clock cycle: drive inputs, update the model, compute expected outputs
  // for every delay at the following negedge.
  task automatic tick(input bit v, input bit w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d, input bit r);
    int s, k, base;
    bit inr;
    @(posedge clk); #1;
    cyc++;
    if (rst_prev) for (int i = 0; i < ND; i++) exp_rdt[i] = 32'h0;
    rst = r; vld = v; wen = w; adr = a; ben = b; wdt = d;
    s = cyc % 16;
    h_cyc[s] = cyc;
    last_trn = v && (rdy_s[1] === 1'b1) && !r;
    h_vld[s] = last_trn;
    if (last_trn) begin
      inr = (a < SIZE);
      h_err[s] = !inr;
      h_upd[s] = !w || !inr;
      h_dat[s] = inr ? mword(a) : 32'h0;
      if (w && inr) begin
        base = int'({a[11:2], 2'b00});
        for (int i = 0; i < 4; i++) if (b[i]) mbyte[base+i] = d[8*i +: 8];
      end
    end
    @(negedge clk);
    for (int dd = 0; dd < ND; dd++) begin
      k = cyc - dd;
      if (k >= 0 && k > last_rst && h_vld[k%16] && h_cyc[k%16] == k) begin
        exp_err[dd] = h_err[k%16];
        if (h_upd[k%16]) exp_rdt[dd] = h_dat[k%16];
      end else begin
        exp_err[dd] = 1'b0;
      end
    end
    if (r) last_rst = cyc;
    rst_prev = r;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  // Hold a request until it is accepted (bounded).
  task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int n;
    n = 0;
    do begin
      tick(1'b1, w, a, b, d, 1'b0);
      n++;
    end while (!last_trn && n < 40);
    total++;
    if (!last_trn) $display("FAIL xfer_timeout adr=%h: not accepted after %0d cycles, required acceptance", a, n);
    else passed++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, (c == 0));
      for (int d = 0; d < ND; d++) begin
        total++;
        if (rdt_s[d] !== 32'h0 || err_s[d] !== 1'b0 || rdy_s[d] !== RDY_IDLE)
          $display("FAIL reset dly=%0d c=%0d rdt=%h err=%b rdy=%b, required rdt=0 err=0 rdy=%b",
                   d, c, rdt_s[d], err_s[d], rdy_s[d], RDY_IDLE);
        else passed++;
      end
    end
  endtask

  task automatic preload();
    for (int i = 0; i < int'(SIZE/4); i++) xfer(1'b1, 32'(i*4), 4'hF, $urandom);
  endtask

  task automatic test_write_read();
    xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 4'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) idle();
      for (int d = 0; d < ND; d++) begin
        total++;
        if (rdt_s[d] !== exp_rdt[d] || err_s[d] !== exp_err[d])
          $display("FAIL wr_rd dly=%0d cyc=%0d rdt=%h err=%b, expected rdt=%h err=%b",
                   d, cyc, rdt_s[d], err_s[d], exp_rdt[d], exp_err[d]);
        else passed++;
      end
      if (c == 1) begin
        total++;
        if (rdt_s[1] !== 32'hDEADBEEF || err_s[1] !== 1'b0)
          $display("FAIL wr_rd_dly1 rdt=%h err=%b, required rdt=deadbeef err=0", rdt_s[1], err_s[1]);
        else passed++;
      end
    end
  endtask

  task automatic test_byte_en();
    xfer(1'b1, 32'h20, 4'hF, 32'h11223344);
    xfer(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    xfer(1'b0, 32'h20, 4'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) idle();
      for (int d = 0; d < ND; d++) begin
        total++;
        if (rdt_s[d] !== exp_rdt[d] || err_s[d] !== exp_err[d])
          $display("FAIL byte_en dly=%0d cyc=%0d rdt=%h err=%b, expected rdt=%h err=%b",
                   d, cyc, rdt_s[d], err_s[d], exp_rdt[d], exp_err[d]);
        else passed++;
      end
    end
    total++;
    if (rdt_s[2] !== 32'h11BB33DD)
      $display("FAIL byte_en_value rdt=%h, required 11bb33dd", rdt_s[2]);
    else passed++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] w1;
    w1 = mword(32'h4);
    xfer(1'b0, 32'h1000, 4'hF, 32'h0);
    total++;
    if (rdt_s[0] !== 32'h0 || err_s[0] !== 1'b1)
      $display("FAIL oor_rd_dly0 rdt=%h err=%b, required rdt=0 err=1", rdt_s[0], err_s[0]);
    else passed++;
    idle();
    total++;
    if (rdt_s[1] !== 32'h0 || err_s[1] !== 1'b1)
      $display("FAIL oor_rd_dly1 rdt=%h err=%b, required rdt=0 err=1", rdt_s[1], err_s[1]);
    else passed++;
    xfer(1'b1, 32'h1004, 4'hF, 32'hCAFEF00D);
    xfer(1'b0, 32'h4, 4'hF, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) idle();
      for (int d = 0; d < ND; d++) begin
        total++;
        if (rdt_s[d] !== exp_rdt[d] || err_s[d] !== exp_err[d])
          $display("FAIL oor dly=%0d cyc=%0d rdt=%h err=%b, expected rdt=%h err=%b",
                   d, cyc, rdt_s[d], err_s[d], exp_rdt[d], exp_err[d]);
        else passed++;
      end
    end
    total++;
    if (rdt_s[3] !== w1)
      $display("FAIL oor_no_wrap rdt=%h, required %h", rdt_s[3], w1);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = mword(32'(i*4));
    for (int i = 0; i < 3; i++) xfer(1'b0, 32'(i*4), 4'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      idle();
      for (int d = 0; d < ND; d++) begin
        total++;
        if (rdt_s[d] !== exp_rdt[d] || err_s[d] !== exp_err[d])
          $display("FAIL b2b dly=%0d cyc=%0d rdt=%h err=%b, expected rdt=%h err=%b",
                   d, cyc, rdt_s[d], err_s[d], exp_rdt[d], exp_err[d]);
        else passed++;
      end
`ifndef TCB_SUB_MEM_WAIT_EN
      if (c < 3) begin
        total++;
        if (rdt_s[3] !== w[c])
          $display("FAIL b2b_dly3 slot=%0d rdt=%h, required %h", c, rdt_s[3], w[c]);
        else passed++;
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    xfer(1'b1, 32'h40, 4'hF, 32'h5A5A1234);
    xfer(1'b0, 32'h40, 4'h0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    total++;
    if (rdt_s[1] !== 32'h5A5A1234)
      $display("FAIL rst_mid_dly1 rdt=%h, required 5a5a1234", rdt_s[1]);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      idle();
      for (int d = 0; d < ND; d++) begin
        total++;
        if (rdt_s[d] !== exp_rdt[d] || err_s[d] !== exp_err[d] || (d > 0 && rdt_s[d] !== 32'h0))
          $display("FAIL rst_mid dly=%0d cyc=%0d rdt=%h err=%b, expected rdt=%h err=%b",
                   d, cyc, rdt_s[d], err_s[d], exp_rdt[d], exp_err[d]);
        else passed++;
      end
    end
    xfer(1'b0, 32'h40, 4'h0, 32'h0);
    idle();
    idle();
    total++;
    if (rdt_s[2] !== 32'h5A5A1234 || err_s[2] !== 1'b0)
      $display("FAIL rst_keep_mem rdt=%h err=%b, required rdt=5a5a1234 err=0", rdt_s[2], err_s[2]);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          w;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        w = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
        else a = 32'($urandom_range(0, SIZE-1));
        xfer(w, a, 4'($urandom), $urandom);
      end
      for (int d = 0; d < ND; d++) begin
        total++;
        if (rdt_s[d] !== exp_rdt[d] || err_s[d] !== exp_err[d])
          $display("FAIL random dly=%0d cyc=%0d rdt=%h err=%b, expected rdt=%h err=%b",
                   d, cyc, rdt_s[d], err_s[d], exp_rdt[d], exp_err[d]);
        else passed++;
      end
    end
  endtask

`ifdef TCB_SUB_MEM_WAIT_EN
  task automatic test_wait();
    int first, second;
    repeat (3) idle();
    first = -1;
    second = -1;
    for (int c = 0; c < 8; c++) begin
      tick(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
      if (rdy_s[1] === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    total++;
    if (first != 3 || second != 7)
      $display("FAIL wait_rdy rdy cycles %0d,%0d, required 3,7", first, second);
    else passed++;
    repeat (4) idle();
  endtask
`endif

  initial begin
    rst = 1'b1; vld = 1'b0; wen = 1'b0; adr = 32'h0; ben = 4'h0; wdt = 32'h0;
    passed = 0; total = 0; cyc = -1; last_rst = -1000; rst_prev = 1'b0; last_trn = 1'b0;
    for (int d = 0; d < ND; d++) begin
      exp_rdt[d] = 32'h0;
      exp_err[d] = 1'b0;
    end
    test_reset();
    preload();
    test_write_read();
    test_byte_en();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef TCB_SUB_MEM_WAIT_EN
    test_wait();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
